// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   ID-stage branch controller for the 5-stage pipeline. It sequences the
//   branch comparator for beq/bne/bgez/bgtz/blez/bltz. It stalls PC and IF/ID
//   until both branch operands can be forwarded, and it drives the operand
//   forwarding selects. On a taken branch it issues the PC redirect and the
//   IF/ID flush.
//
// Optional feature: define BRANCH_STATS_EN to add three CNT_W-bit statistics
//   counters. They count resolved branches, taken branches and stall cycles.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ID_Branch, ID_ALUCode       branch valid / branch code in ID
//   ID_RsAddr, ID_RtAddr        branch source registers
//   EX_/MEM_/WB_ RegWrite,      destination info of older instructions
//     MemRead, WriteReg           (WB has no load flag)
//   Z                           comparator result on forwarded operands
//   Stall                       hold PC and IF/ID, bubble into ID/EX
//   Flush_IFID, PCSrc_Br        taken-branch squash and redirect
//   ForwardRs, ForwardRt        00 regfile, 01 EX/MEM ALU, 10 MEM/WB data
//   Resolved                    branch evaluated this cycle
//   StatBranches, StatTaken,
//   StatStallCyc                statistics (BRANCH_STATS_EN only)
module branch_resolve_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_Branch,
  input  logic [4:0]       ID_ALUCode,
  input  logic [4:0]       ID_RsAddr,
  input  logic [4:0]       ID_RtAddr,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_WriteReg,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_WriteReg,
  input  logic             Z,
  output logic             Stall,
  output logic             Flush_IFID,
  output logic             PCSrc_Br,
  output logic [1:0]       ForwardRs,
  output logic [1:0]       ForwardRt,
  output logic             Resolved
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] StatBranches,
  output logic [CNT_W-1:0] StatTaken,
  output logic [CNT_W-1:0] StatStallCyc
`endif
);

  localparam logic [4:0] CODE_BEQ  = 5'b01010;
  localparam logic [4:0] CODE_BNE  = 5'b01011;
  localparam logic [4:0] CODE_BLTZ = 5'b01111;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t     state, nextState;
  logic [1:0] cnt, nextCnt;

  logic       branchValid;
  logic       usesRt;
  logic       rsEx, rsMem, rsWb;
  logic       rtEx, rtMem, rtWb;
  logic [1:0] needRs, needRt, stallNeed;
  logic       resolveNow;

  // Operand matching. Register 0 never matches. rt is not an operand of the
  // single-register compares, so it is masked out for those codes.
  always_comb begin
    // Outputs are also gated by rst_n, so they drop as soon as reset is
    // asserted rather than at the next clock edge.
    branchValid = rst_n && ID_Branch &&
                  (ID_ALUCode >= CODE_BEQ) && (ID_ALUCode <= CODE_BLTZ);
    usesRt      = (ID_ALUCode == CODE_BEQ) || (ID_ALUCode == CODE_BNE);

    rsEx  = EX_RegWrite  && (EX_WriteReg  == ID_RsAddr) && (ID_RsAddr != '0);
    rsMem = MEM_RegWrite && (MEM_WriteReg == ID_RsAddr) && (ID_RsAddr != '0);
    rsWb  = WB_RegWrite  && (WB_WriteReg  == ID_RsAddr) && (ID_RsAddr != '0);

    rtEx  = usesRt && EX_RegWrite  && (EX_WriteReg  == ID_RtAddr) && (ID_RtAddr != '0);
    rtMem = usesRt && MEM_RegWrite && (MEM_WriteReg == ID_RtAddr) && (ID_RtAddr != '0);
    rtWb  = usesRt && WB_RegWrite  && (WB_WriteReg  == ID_RtAddr) && (ID_RtAddr != '0);
  end

  // Stall cycles still needed per operand. A load in EX needs two cycles.
  // An ALU result in EX needs one. A load in MEM needs one more.
  always_comb begin
    if (rsEx)                    needRs = EX_MemRead ? 2'd2 : 2'd1;
    else if (rsMem && MEM_MemRead) needRs = 2'd1;
    else                         needRs = 2'd0;

    if (rtEx)                    needRt = EX_MemRead ? 2'd2 : 2'd1;
    else if (rtMem && MEM_MemRead) needRt = 2'd1;
    else                         needRt = 2'd0;

    stallNeed = (needRs > needRt) ? needRs : needRt;
  end

  // Forwarding selects follow the live pipeline inputs. An ALU result in
  // MEM wins over a writer in WB. A load still in MEM is never forwarded.
  always_comb begin
    ForwardRs = 2'b00;
    ForwardRt = 2'b00;
    if (branchValid) begin
      if (rsMem && !MEM_MemRead) ForwardRs = 2'b01;
      else if (rsWb)             ForwardRs = 2'b10;
      if (rtMem && !MEM_MemRead) ForwardRt = 2'b01;
      else if (rtWb)             ForwardRt = 2'b10;
    end
  end

  // Next-state and stall logic. An invalid or absent branch leaves the
  // state and counter untouched.
  always_comb begin
    nextState  = state;
    nextCnt    = cnt;
    Stall      = 1'b0;
    resolveNow = 1'b0;
    if (branchValid) begin
      unique case (state)
        S_IDLE: begin
          if (stallNeed == 2'd0) begin
            resolveNow = 1'b1;
          end else begin
            Stall     = 1'b1;
            nextCnt   = stallNeed - 2'd1;
            nextState = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            Stall   = 1'b1;
            nextCnt = cnt - 2'd1;
          end else begin
            resolveNow = 1'b1;
            nextState  = S_IDLE;
          end
        end
        default: nextState = S_IDLE;
      endcase
    end
  end

  // A resolve cycle never stalls, so Stall and Flush_IFID are exclusive.
  always_comb begin
    Resolved   = resolveNow;
    PCSrc_Br   = resolveNow && Z;
    Flush_IFID = resolveNow && Z;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

`ifdef BRANCH_STATS_EN
  // Free-running statistics. They wrap at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StatBranches <= '0;
      StatTaken    <= '0;
      StatStallCyc <= '0;
    end else begin
      if (Resolved)       StatBranches <= StatBranches + 1'b1;
      if (Resolved && Z)  StatTaken    <= StatTaken + 1'b1;
      if (Stall)          StatStallCyc <= StatStallCyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ID_Branch;
  logic [4:0] ID_ALUCode, ID_RsAddr, ID_RtAddr;
  logic       EX_RegWrite, EX_MemRead;
  logic [4:0] EX_WriteReg;
  logic       MEM_RegWrite, MEM_MemRead;
  logic [4:0] MEM_WriteReg;
  logic       WB_RegWrite;
  logic [4:0] WB_WriteReg;
  logic       Z;
  logic       Stall, Flush_IFID, PCSrc_Br, Resolved;
  logic [1:0] ForwardRs, ForwardRt;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] StatBranches, StatTaken, StatStallCyc;
`endif

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Branch(ID_Branch), .ID_ALUCode(ID_ALUCode),
    .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .Z(Z),
    .Stall(Stall), .Flush_IFID(Flush_IFID), .PCSrc_Br(PCSrc_Br),
    .ForwardRs(ForwardRs), .ForwardRt(ForwardRt), .Resolved(Resolved)
`ifdef BRANCH_STATS_EN
    ,
    .StatBranches(StatBranches), .StatTaken(StatTaken), .StatStallCyc(StatStallCyc)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Pipeline model: instructions flow ID -> EX -> MEM -> WB.
  typedef struct { bit wr; bit ld; int dst; } stage_t;
  typedef struct { bit br; logic [4:0] code; int rs; int rt; bit wr; bit ld; int dst; } instr_t;

  stage_t ex, mem, wb;
  instr_t id;
  bit     zIn;
  bit [31:0] expBr, expTk, expSt;

  function automatic stage_t mkStage(bit wr, bit ld, int dst);
    stage_t s;
    s.wr = wr; s.ld = ld; s.dst = dst;
    return s;
  endfunction

  function automatic instr_t mkBr(logic [4:0] code, int rs, int rt);
    instr_t i;
    i.br = 1'b1; i.code = code; i.rs = rs; i.rt = rt; i.wr = 1'b0; i.ld = 1'b0; i.dst = 0;
    return i;
  endfunction

  function automatic instr_t nop();
    instr_t i;
    i.br = 1'b0; i.code = 5'd0; i.rs = 0; i.rt = 0; i.wr = 1'b0; i.ld = 1'b0; i.dst = 0;
    return i;
  endfunction

  function automatic bit isBranch(instr_t i);
    return i.br && (i.code >= 5'd10) && (i.code <= 5'd15);
  endfunction

  function automatic bit usesRt(instr_t i);
    return (i.code == 5'd10) || (i.code == 5'd11);
  endfunction

  // Cycles until register r can be obtained by forwarding.
  function automatic int stallsFor(int r);
    if (r == 0) return 0;
    if (ex.wr && ex.dst == r) return ex.ld ? 2 : 1;
    if (mem.wr && mem.dst == r && mem.ld) return 1;
    return 0;
  endfunction

  function automatic int fwdFor(int r);
    if (r == 0) return 0;
    if (mem.wr && mem.dst == r && !mem.ld) return 1;
    if (wb.wr && wb.dst == r) return 2;
    return 0;
  endfunction

  function automatic int expNeed();
    int a, b;
    a = stallsFor(id.rs);
    b = usesRt(id) ? stallsFor(id.rt) : 0;
    return (a > b) ? a : b;
  endfunction

  function automatic instr_t genInstr();
    instr_t i;
    int k;
    k     = $urandom_range(0, 99);
    i.rs  = $urandom_range(0, 7);
    i.rt  = $urandom_range(0, 7);
    i.dst = $urandom_range(0, 7);
    if (k < 45) begin
      i.br = 1'b1; i.code = 5'($urandom_range(10, 15)); i.wr = 1'b0; i.ld = 1'b0;
    end else if (k < 52) begin
      i.br = 1'b1; i.code = ($urandom_range(0, 1) == 0) ? 5'd9 : 5'd16; i.wr = 1'b0; i.ld = 1'b0;
    end else begin
      i.br = 1'b0; i.code = 5'($urandom_range(0, 31));
      i.wr = ($urandom_range(0, 4) != 0);
      i.ld = i.wr && ($urandom_range(0, 2) == 0);
    end
    return i;
  endfunction

  task automatic clearPipe();
    ex = mkStage(0, 0, 0); mem = mkStage(0, 0, 0); wb = mkStage(0, 0, 0); id = nop();
  endtask

  task automatic drive();
    ID_Branch    = id.br;
    ID_ALUCode   = id.code;
    ID_RsAddr    = 5'(id.rs);
    ID_RtAddr    = 5'(id.rt);
    EX_RegWrite  = ex.wr;  EX_MemRead  = ex.ld;  EX_WriteReg  = 5'(ex.dst);
    MEM_RegWrite = mem.wr; MEM_MemRead = mem.ld; MEM_WriteReg = 5'(mem.dst);
    WB_RegWrite  = wb.wr;  WB_WriteReg = 5'(wb.dst);
    Z            = zIn;
  endtask

  // The pipeline advances by one cycle. A stalled branch stays in ID and a
  // bubble enters EX.
  task automatic stepPipe(input instr_t nextId);
    bit st;
    st  = isBranch(id) && (expNeed() > 0);
    wb  = mem;
    mem = ex;
    if (st) begin
      ex = mkStage(0, 0, 0);
    end else begin
      ex = id.br ? mkStage(0, 0, 0) : mkStage(id.wr, id.ld, id.dst);
      id = nextId;
    end
  endtask

  function automatic logic [7:0] obsVec();
    return {Stall, Flush_IFID, PCSrc_Br, Resolved, ForwardRs, ForwardRt};
  endfunction

  task automatic test_reset();
    logic [7:0] o;
    clearPipe();
    id = mkBr(5'b01010, 1, 2);
    ex = mkStage(1, 1, 1);
    zIn = 1'b1;
    @(negedge clk); drive(); #1;
    o = obsVec();
    total++;
    if (o !== 8'b0000_0000) begin bad++; $display("FAIL reset_outputs: got %b want %b", o, 8'b0); end
`ifdef BRANCH_STATS_EN
    total++;
    if ({StatBranches, StatTaken, StatStallCyc} !== '0) begin
      bad++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", StatBranches, StatTaken, StatStallCyc);
    end
`endif
    clearPipe(); drive();
    rst_n = 1'b1;
  endtask

  task automatic test_no_hazard();
    logic [7:0] o;
    clearPipe();
    id = mkBr(5'b01010, 1, 2); zIn = 1'b1;
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b0111_0000) begin bad++; $display("FAIL beq_nohazard: got %b want %b", o, 8'b0111_0000); end
    stepPipe(nop());
  endtask

  task automatic test_alu_ex();
    logic [7:0] o;
    clearPipe();
    ex = mkStage(1, 0, 3); id = mkBr(5'b01101, 3, 0); zIn = 1'b1;
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b1000_0000) begin bad++; $display("FAIL alu_ex_stall: got %b want %b", o, 8'b1000_0000); end
    stepPipe(nop());
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b0111_0100) begin bad++; $display("FAIL alu_ex_resolve: got %b want %b", o, 8'b0111_0100); end
    stepPipe(nop());
  endtask

  task automatic test_load_ex();
    logic [7:0] o;
    clearPipe();
    ex = mkStage(1, 1, 4); id = mkBr(5'b01011, 5, 4); zIn = 1'b0;
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b1000_0000) begin bad++; $display("FAIL load_stall1: got %b want %b", o, 8'b1000_0000); end
    stepPipe(nop());
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b1000_0000) begin bad++; $display("FAIL load_stall2: got %b want %b", o, 8'b1000_0000); end
    stepPipe(nop());
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b0001_0010) begin bad++; $display("FAIL load_resolve: got %b want %b", o, 8'b0001_0010); end
    stepPipe(nop());
  endtask

  task automatic test_ex_mem_both();
    logic [7:0] o;
    clearPipe();
    ex = mkStage(1, 0, 6); mem = mkStage(1, 0, 6); id = mkBr(5'b01010, 6, 6); zIn = 1'b1;
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b1000_0101) begin bad++; $display("FAIL exmem_stall: got %b want %b", o, 8'b1000_0101); end
    stepPipe(nop());
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b0111_0101) begin bad++; $display("FAIL exmem_resolve: got %b want %b", o, 8'b0111_0101); end
    stepPipe(nop());
  endtask

  task automatic test_zero_reg();
    logic [7:0] o;
    clearPipe();
    ex = mkStage(1, 0, 0); mem = mkStage(1, 0, 0); id = mkBr(5'b01111, 0, 0); zIn = 1'b1;
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b0111_0000) begin bad++; $display("FAIL reg0_bltz: got %b want %b", o, 8'b0111_0000); end
    clearPipe();
    ex = mkStage(1, 1, 7); id = mkBr(5'b01100, 1, 7); zIn = 1'b0;
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b0001_0000) begin bad++; $display("FAIL bgez_rt_ignored: got %b want %b", o, 8'b0001_0000); end
    stepPipe(nop());
  endtask

  task automatic test_invalid();
    logic [7:0] o;
    logic [4:0] codes [3];
    bit         brs [3];
    codes[0] = 5'b01001; brs[0] = 1'b1;
    codes[1] = 5'b10000; brs[1] = 1'b1;
    codes[2] = 5'b01010; brs[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clearPipe();
      ex = mkStage(1, 1, 3); mem = mkStage(1, 0, 2);
      id = mkBr(codes[k], 2, 3); id.br = brs[k]; zIn = 1'b1;
      @(negedge clk); drive(); #1; o = obsVec();
      total++;
      if (o !== 8'b0000_0000) begin bad++; $display("FAIL invalid_%0d: got %b want %b", k, o, 8'b0); end
    end
    clearPipe();
  endtask

  task automatic test_back_to_back();
    logic [7:0] o;
    clearPipe();
    ex = mkStage(1, 0, 1); id = mkBr(5'b01010, 1, 2); zIn = 1'b1;
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b1000_0000) begin bad++; $display("FAIL b2b_stall: got %b want %b", o, 8'b1000_0000); end
    stepPipe(nop());
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b0111_0100) begin bad++; $display("FAIL b2b_first: got %b want %b", o, 8'b0111_0100); end
    stepPipe(mkBr(5'b01011, 1, 3));
    zIn = 1'b0;
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b0001_1000) begin bad++; $display("FAIL b2b_second: got %b want %b", o, 8'b0001_1000); end
    stepPipe(nop());
  endtask

  task automatic test_reset_mid_stall();
    logic [7:0] o;
    clearPipe();
    ex = mkStage(1, 1, 4); id = mkBr(5'b01011, 5, 4); zIn = 1'b1;
    @(negedge clk); drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b1000_0000) begin bad++; $display("FAIL rst_pre_stall: got %b want %b", o, 8'b1000_0000); end
    stepPipe(nop());
    @(negedge clk); drive(); #1;
    #1 rst_n = 1'b0;
    #1 o = obsVec();
    total++;
    if (o !== 8'b0000_0000) begin bad++; $display("FAIL rst_mid_outputs: got %b want %b", o, 8'b0); end
`ifdef BRANCH_STATS_EN
    total++;
    if (StatBranches !== '0 || StatStallCyc !== '0) begin
      bad++; $display("FAIL rst_mid_stats: got br=%0d st=%0d want 0/0", StatBranches, StatStallCyc);
    end
`endif
    @(negedge clk);
    clearPipe();
    id = mkBr(5'b01011, 5, 4); zIn = 1'b1;
    rst_n = 1'b1;
    drive(); #1; o = obsVec();
    total++;
    if (o !== 8'b0111_0000) begin bad++; $display("FAIL rst_idle_after: got %b want %b", o, 8'b0111_0000); end
    stepPipe(nop());
    expBr = 32'd1; expTk = 32'd1; expSt = 32'd0;
  endtask

  task automatic test_random();
    logic [7:0] o, e;
    bit v, res, st;
    int n, fr, ft;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      zIn = 1'($urandom_range(0, 1));
      drive(); #1;
      v   = isBranch(id);
      n   = expNeed();
      st  = v && (n > 0);
      res = v && (n == 0);
      fr  = v ? fwdFor(id.rs) : 0;
      ft  = (v && usesRt(id)) ? fwdFor(id.rt) : 0;
      e   = {st, res && zIn, res && zIn, res, 2'(fr), 2'(ft)};
      o   = obsVec();
      total++;
      if (o !== e) begin
        bad++; $display("FAIL rand_cycle%0d: got %b want %b", c, o, e);
      end
      if (Resolved === 1'b1) begin
        total++;
        if (n != 0) begin bad++; $display("FAIL rand_resolve_need%0d: got need=%0d want 0", c, n); end
      end
      total++;
      if (Stall === 1'b1 && Flush_IFID === 1'b1) begin
        bad++; $display("FAIL rand_stall_flush%0d: got both=1 want not both", c);
      end
      expBr += 32'(res);
      expTk += 32'(res && zIn);
      expSt += 32'(st);
      stepPipe(genInstr());
    end
`ifdef BRANCH_STATS_EN
    @(negedge clk); #1;
    total++;
    if (StatBranches !== expBr || StatTaken !== expTk || StatStallCyc !== expSt) begin
      bad++;
      $display("FAIL rand_stats: got %0d/%0d/%0d want %0d/%0d/%0d",
               StatBranches, StatTaken, StatStallCyc, expBr, expTk, expSt);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    zIn   = 1'b0;
    expBr = '0; expTk = '0; expSt = '0;
    clearPipe();
    drive();
    test_reset();
    test_no_hazard();
    test_alu_ex();
    test_load_ex();
    test_ex_mem_both();
    test_zero_reg();
    test_invalid();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
